// File: rtl/aes_sbox_pkg.sv
// Shared GF((2^4)^2) arithmetic, basis-change matrices and stage payload for the AES S-box lanes.
// Matrices are packed {row7..row0}; each row is the input-bit mask that XORs into that output bit.
package aes_sbox_pkg;

    // Mapping between the AES polynomial basis and the tower basis (and back).
    localparam logic [63:0] ISO_M        = 64'hA0DE_ACAE_C69E_5243;
    localparam logic [63:0] INV_ISO_M    = 64'hE244_6276_3E9E_3075;
    localparam logic [63:0] AFFINE_M     = 64'hF87C_3E1F_8FC7_E3F1;
    localparam logic [63:0] INV_AFFINE_M = 64'h5229_944A_2592_49A4;
    localparam logic [7:0]  AFFINE_C     = 8'h63;
    localparam logic [7:0]  INV_AFFINE_C = 8'h05;

    // lambda in z^2 + z + lambda over GF(16); GF(16) is GF(4)[y]/(y^2 + y + x)
    localparam logic [3:0]  GF16_V       = 4'hC;

    typedef struct packed {
        logic [3:0] g1;
        logic [3:0] g0;   // g0 after S1, g0^g1 after S2
        logic [3:0] nib;  // S1 sum, then its GF(16) inverse
        logic       inv;
    } stage_t;

    function automatic logic [7:0] mat_mul8(input logic [63:0] m, input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) begin
            y[i] = ^(m[8*i +: 8] & x);
        end
        return y;
    endfunction

    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
                (a[1] & b[1]) ^ (a[0] & b[0])};
    endfunction

    function automatic logic [1:0] gf4_mul_phi(input logic [1:0] a);
        return {a[1] ^ a[0], a[1]};
    endfunction

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh;
        logic [1:0] hl;
        logic [1:0] lh;
        logic [1:0] ll;
        hh = gf4_mul(a[3:2], b[3:2]);
        hl = gf4_mul(a[3:2], b[1:0]);
        lh = gf4_mul(a[1:0], b[3:2]);
        ll = gf4_mul(a[1:0], b[1:0]);
        return {hh ^ hl ^ lh, gf4_mul_phi(hh) ^ ll};
    endfunction

    function automatic logic [3:0] gf16_sq(input logic [3:0] a);
        return gf16_mul(a, a);
    endfunction

    function automatic logic [3:0] gf16_sq_mul_v(input logic [3:0] a);
        return gf16_mul(GF16_V, gf16_sq(a));
    endfunction

    // a^14 = a^-1 for a != 0, and maps 0 to 0 with no special case
    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] a2;
        logic [3:0] a4;
        logic [3:0] a8;
        a2 = gf16_sq(a);
        a4 = gf16_sq(a2);
        a8 = gf16_sq(a4);
        return gf16_mul(gf16_mul(a2, a4), a8);
    endfunction

endpackage

// File: rtl/sbox_lane_stages.sv
// Combinational logic of the three S-box stages for one byte lane; registers live in the top.
// SBOX_INV_EN enables the inverse-affine input path and the output mode mux.
module sbox_lane_stages
    import aes_sbox_pkg::*;
(
    input  logic [7:0] s1_byte_i,
    input  logic       s1_inv_i,
    output stage_t     s1_o,
    input  stage_t     s2_i,
    output stage_t     s2_o,
    input  stage_t     s3_i,
    output logic [7:0] s3_byte_o
);

    logic [7:0] s1_pre;
    logic       s1_inv;
    logic [7:0] s1_iso;
    logic [3:0] d1;
    logic [3:0] d0;
    logic [7:0] s3_base;
    logic [7:0] s3_fwd;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        s1_pre = s1_byte_i;
        s1_inv = 1'b0;
`ifdef SBOX_INV_EN
        if (s1_inv_i) begin
            s1_pre = mat_mul8(INV_AFFINE_M, s1_byte_i) ^ INV_AFFINE_C;
            s1_inv = 1'b1;
        end
`endif
    end

    assign s1_iso = mat_mul8(ISO_M, s1_pre);

    always_comb begin
        s1_o     = '0;
        s1_o.g1  = s1_iso[7:4];
        s1_o.g0  = s1_iso[3:0];
        s1_o.nib = gf16_mul(s1_iso[7:4], s1_iso[3:0]) ^ gf16_sq(s1_iso[3:0])
                 ^ gf16_sq_mul_v(s1_iso[7:4]);
        s1_o.inv = s1_inv;
    end

    always_comb begin
        s2_o     = '0;
        s2_o.g1  = s2_i.g1;
        s2_o.g0  = s2_i.g0 ^ s2_i.g1;
        s2_o.nib = gf16_inv(s2_i.nib);
        s2_o.inv = s2_i.inv;
    end

    assign d1      = gf16_mul(s3_i.g1, s3_i.nib);
    assign d0      = gf16_mul(s3_i.g0, s3_i.nib);
    assign s3_base = mat_mul8(INV_ISO_M, {d1, d0});
    assign s3_fwd  = mat_mul8(AFFINE_M, s3_base) ^ AFFINE_C;

`ifdef SBOX_INV_EN
    assign s3_byte_o = s3_i.inv ? s3_base : s3_fwd;
`else
    logic unused_inv;
    assign unused_inv = s1_inv_i ^ s3_i.inv;
    assign s3_byte_o  = s3_fwd;
`endif

endmodule

// File: rtl/sbox_lane_pipe.sv
// NUM_LANES-wide, 3-stage composite-field AES S-box with valid/ready flow control and a tag sideband.
// Define SBOX_INV_EN to honour in_inv per beat; otherwise every beat takes the forward S-box.
module sbox_lane_pipe
    import aes_sbox_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int TAG_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_LANES-1:0] in_data,
    input  logic                   in_inv,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_LANES-1:0] out_data,
    output logic [TAG_W-1:0]       out_tag
);

    logic                   advance;
    logic                   v1_q;
    logic                   v2_q;
    logic                   v3_q;
    stage_t [NUM_LANES-1:0] s1_d;
    stage_t [NUM_LANES-1:0] s1_q;
    stage_t [NUM_LANES-1:0] s2_d;
    stage_t [NUM_LANES-1:0] s2_q;
    logic [8*NUM_LANES-1:0] s3_d;
    logic [8*NUM_LANES-1:0] s3_q;
    logic [TAG_W-1:0]       tag1_q;
    logic [TAG_W-1:0]       tag2_q;
    logic [TAG_W-1:0]       tag3_q;

    // Whole pipeline moves together; it only stalls when a beat sits unaccepted at the output.
    assign advance   = out_ready | ~v3_q;
    assign in_ready  = advance;
    assign out_valid = v3_q;
    assign out_data  = s3_q;
    assign out_tag   = tag3_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sbox_lane_stages u_lane (
            .s1_byte_i (in_data[8*g +: 8]),
            .s1_inv_i  (in_inv),
            .s1_o      (s1_d[g]),
            .s2_i      (s1_q[g]),
            .s2_o      (s2_d[g]),
            .s3_i      (s2_q[g]),
            .s3_byte_o (s3_d[8*g +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
        end else if (advance) begin
            // NOTE: non-blocking so each stage captures the previous stage's pre-edge value.
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) begin
                s1_q   <= s1_d;
                tag1_q <= in_tag;
            end
            if (v1_q) begin
                s2_q   <= s2_d;
                tag2_q <= tag1_q;
            end
            if (v2_q) begin
                s3_q   <= s3_d;
                tag3_q <= tag2_q;
            end
        end
    end

endmodule

// File: tb/tb_sbox_lane_pipe.sv
// Scoreboard bench for sbox_lane_pipe: directed vectors, table sweep, stall, mid-flight reset.
// Expectations for in_inv=1 beats follow SBOX_INV_EN, matching the build under test.
module tb_sbox_lane_pipe;

    localparam int NL = 4;
    localparam int DW = 8 * NL;
`ifdef SBOX_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_inv;
    logic [3:0]    in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [3:0]    out_tag;

    int   n_cmp       = 0;
    int   n_bad       = 0;
    int   cyc         = 0;
    int   rx_count    = 0;
    int   rx_last_cyc = 0;
    exp_t sb[$];

    // FIPS-197 forward S-box, one row of 16 bytes per entry, byte 0 in the top bits.
    logic [127:0] fwd_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    sbox_lane_pipe #(
        .NUM_LANES (NL),
        .TAG_W     (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_beat(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] r;
        for (int j = 0; j < NL; j++) begin
            r[8*j +: 8] = (inv && INV_EN) ? inv_tab[d[8*j +: 8]] : fwd_tab[d[8*j +: 8]];
        end
        return r;
    endfunction

    // Monitor: every output transfer pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got data=%0h tag=%0h, required no beat", out_data, out_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", {96'd0, out_data}, {96'd0, e.data});
                check("out_tag", {124'd0, out_tag}, {124'd0, e.tag});
                rx_count++;
                rx_last_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 after the beat was taken, pres = presenting cycle.
    task automatic send(input logic [DW-1:0] d, input logic inv, input logic [3:0] t,
                        input logic [DW-1:0] exp, output int pres);
        int   guard;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        in_tag   = t;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            $display("FAIL send_timeout: in_ready stuck at 0, required 1 within 50 cycles");
            $fatal(1);
        end
        pres   = cyc;
        e.data = exp;
        e.tag  = t;
        sb.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("drain_empty", 128'(sb.size()), 128'd0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            pres;
        int            first;
        int            rel;
        int            hi;
        int            rx0;
        logic [DW-1:0] d;

        for (int i = 0; i < 256; i++) begin
            fwd_tab[i] = fwd_rows[i >> 4][127 - 8*(i & 15) -: 8];
        end
        for (int i = 0; i < 256; i++) begin
            inv_tab[fwd_tab[i]] = 8'(i);
        end

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", 128'(out_data), 128'd0);
        check("rst_out_tag", 128'(out_tag), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        step();
        rst_n = 1'b1;

        // Single forward beat: latency and one-cycle valid pulse.
        send(32'hFF53_0100, 1'b0, 4'h5, 32'h16ED_7C63, pres);
        hi = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) hi++;
        end
        check("single_valid_cycles", 128'(hi), 128'd1);
        check("single_latency", 128'(rx_last_cyc - pres), 128'd3);
        step();

        // Forward/inverse interleaved back-to-back.
        send(32'hFF53_0100, 1'b0, 4'h1, 32'h16ED_7C63, pres);
        send(32'h16ED_7C63, 1'b1, 4'h2, INV_EN ? 32'hFF53_0100 : 32'h4755_10FB, pres);
        send(32'h16ED_7C63, 1'b0, 4'h3, 32'h4755_10FB, pres);
        send(32'h0000_0053, 1'b1, 4'h4, INV_EN ? 32'h5252_5250 : 32'h6363_63ED, pres);
        drain();

        // All 256 bytes in each mode, one beat per cycle.
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 256 / NL; k++) begin
                for (int j = 0; j < NL; j++) d[8*j +: 8] = 8'(k * NL + j);
                send(d, m[0], 4'(k), exp_beat(d, m[0]), pres);
                if (k == 0) first = pres;
            end
            drain();
            check(m == 0 ? "sweep_fwd_rate" : "sweep_inv_rate", 128'(rx_last_cyc - first), 128'(256 / NL + 2));
        end

        // Backpressure: fill three beats, stall five cycles, release while streaming more.
        rx0       = rx_count;
        out_ready = 1'b0;
        send(32'h0302_0100, 1'b0, 4'hA, 32'h7B77_7C63, pres);
        send(32'h0706_0504, 1'b0, 4'hB, 32'hC56F_6BF2, pres);
        send(32'h0B0A_0908, 1'b0, 4'hC, 32'h2B67_0130, pres);
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 128'(in_ready), 128'd0);
            check("stall_out_valid", 128'(out_valid), 128'd1);
            check("stall_out_data", 128'(out_data), 128'h7B77_7C63);
            check("stall_out_tag", 128'(out_tag), 128'hA);
        end
        step();
        out_ready = 1'b1;
        rel       = cyc;
        for (int k = 0; k < 3; k++) begin
            d = 32'hC0C1_C2C3 ^ DW'(k * 32'h1111_1111);
            send(d, k[0], 4'(k), exp_beat(d, k[0]), pres);
        end
        drain();
        check("bp_release_rate", 128'(rx_last_cyc - rel), 128'd5);
        check("bp_rx_count", 128'(rx_count - rx0), 128'd6);

        // Reset with two beats in flight: nothing may come out afterwards.
        rx0 = rx_count;
        send(32'h1234_5678, 1'b0, 4'h7, exp_beat(32'h1234_5678, 1'b0), pres);
        send(32'h9ABC_DEF0, 1'b1, 4'h8, exp_beat(32'h9ABC_DEF0, 1'b1), pres);
        rst_n = 1'b0;
        sb.delete();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_out_data", 128'(out_data), 128'd0);
        check("midrst_out_tag", 128'(out_tag), 128'd0);
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) hi++;
        end
        check("midrst_no_stale", 128'(hi), 128'd0);
        check("midrst_rx_count", 128'(rx_count - rx0), 128'd0);
        step();

        send(32'h0000_0053, 1'b1, 4'h9, INV_EN ? 32'h5252_5250 : 32'h6363_63ED, pres);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
